// File: rtl/data_sram_resp.sv
// data_sram_resp -- single-port word-addressed data SRAM for the memory stage.
//
// After reset the block walks every word writing zero (INIT), then raises
// ready and serves one read or byte-lane write per cycle (RUN). Reads return
// data one cycle after the request. Out-of-range or misaligned requests are
// dropped, return zero, and latch a sticky error with the first bad address.
//
// Parameters:
//   DEPTH_LOG2  log2 of the number of 32-bit words
//   BASE_ADDR   byte address of word 0
// Ports:
//   clk                 clock, rising edge
//   rstn                asynchronous active-low reset
//   data_sram_en        request valid this cycle
//   data_sram_we        byte-lane write enables (0 = read)
//   data_sram_addr      byte address
//   data_sram_wdata     store data
//   data_sram_rdata     registered read data (1-cycle latency)
//   data_sram_ready     high once initialisation has completed
//   data_sram_err       sticky access-error flag
//   data_sram_err_addr  address of the first erroring access
module data_sram_resp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_ready,
  output logic        data_sram_err,
  output logic [31:0] data_sram_err_addr
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  // Byte span of the memory, one bit wider than an address so the range
  // compare stays correct even when the memory covers the whole space.
  localparam logic [32:0]         SPAN = 33'(WORDS) * 33'd4;
  localparam logic [DEPTH_LOG2:0] LAST = {1'b0, {DEPTH_LOG2{1'b1}}};
  localparam logic [DEPTH_LOG2:0] ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  // One bit wider than the index so the final increment does not wrap.
  logic [DEPTH_LOG2:0]   counter;
  logic [31:0]           mem [WORDS];

  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] index;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  access_err;

  logic [3:0]            wr_lanes;
  logic [DEPTH_LOG2-1:0] wr_index;
  logic [31:0]           wr_data;

  assign offset       = data_sram_addr - BASE_ADDR;
  assign index        = offset[DEPTH_LOG2+1:2];
  assign out_of_range = ({1'b0, offset} >= SPAN);
  assign misaligned   = |data_sram_addr[1:0];
  assign access_err   = out_of_range | misaligned;

  // Single write port shared between the zero-fill walk and normal stores.
  always_comb begin
    wr_lanes = 4'b0000;
    wr_index = '0;
    wr_data  = 32'h0;
    if (state == INIT) begin
      wr_lanes = 4'b1111;
      wr_index = counter[DEPTH_LOG2-1:0];
    end else if (data_sram_en && !access_err) begin
      wr_lanes = data_sram_we;
      wr_index = index;
      wr_data  = data_sram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_lanes[i]) begin
        mem[wr_index][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= INIT;
      counter            <= '0;
      data_sram_rdata    <= 32'h0;
      data_sram_ready    <= 1'b0;
      data_sram_err      <= 1'b0;
      data_sram_err_addr <= 32'h0;
    end else begin
      case (state)
        INIT: begin
          // Requests arriving here are ignored entirely.
          counter <= counter + ONE;
          if (counter == LAST) begin
            state           <= RUN;
            data_sram_ready <= 1'b1;
          end
        end
        RUN: begin
          if (data_sram_en) begin
            if (access_err) begin
              data_sram_rdata <= 32'h0;
              data_sram_err   <= 1'b1;
              if (!data_sram_err) begin
                data_sram_err_addr <= data_sram_addr;
              end
            end else if (data_sram_we == 4'b0000) begin
              // The write port commits on the same edges, so a read in
              // the cycle after a store already sees the new word.
              data_sram_rdata <= mem[index];
            end
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp with DEPTH_LOG2=4 (16 words), BASE_ADDR=0.
module tb_data_sram_resp;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  data_sram_resp #(
    .DEPTH_LOG2(4),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .data_sram_en      (en),
    .data_sram_we      (we),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_rdata   (rdata),
    .data_sram_ready   (ready),
    .data_sram_err     (err),
    .data_sram_err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    en    = e;
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
    $display("check %-14s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    #2;
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    cyc();
    cyc();
    rstn = 1'b1;

    // INIT: a write to word 0 and a misaligned read are both ignored.
    for (int i = 1; i <= 16; i++) begin
      if (i <= 3)       drive(1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF);
      else if (i == 4)  drive(1'b1, 4'h0, 32'h6, 32'h0);
      else              drive(1'b0, 4'h0, 32'h0, 32'h0);
      cyc();
      check($sformatf("init1_ready%0d", i), {31'h0, ready}, (i == 16) ? 32'h1 : 32'h0);
    end
    check("init_err", {31'h0, err}, 32'h0);
    check("init_rdata", rdata, 32'h0);

    // Every word reads zero, back-to-back.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'h0, 32'(i * 4), 32'h0);
      cyc();
      check($sformatf("zero_w%0d", i), rdata, 32'h0);
    end

    // Full write then read-after-write.
    drive(1'b1, 4'hF, 32'h8, 32'hDEAD_BEEF);
    cyc();
    check("wr_hold", rdata, 32'h0);
    drive(1'b1, 4'h0, 32'h8, 32'h0);
    cyc();
    check("raw_full", rdata, 32'hDEAD_BEEF);

    // Partial write: lanes 0 and 2.
    drive(1'b1, 4'b0101, 32'h8, 32'h1122_3344);
    cyc();
    check("pwr_hold", rdata, 32'hDEAD_BEEF);
    drive(1'b1, 4'h0, 32'h8, 32'h0);
    cyc();
    check("raw_partial", rdata, 32'hDE22_BE44);

    drive(1'b1, 4'hF, 32'h0, 32'hA5A5_A5A5);
    cyc();
    drive(1'b1, 4'hF, 32'h4, 32'h0102_0304);
    cyc();
    drive(1'b1, 4'b1000, 32'h3C, 32'h7700_0000);
    cyc();

    // Back-to-back reads then idle hold.
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    cyc();
    check("b2b_0", rdata, 32'hA5A5_A5A5);
    drive(1'b1, 4'h0, 32'h4, 32'h0);
    cyc();
    check("b2b_4", rdata, 32'h0102_0304);
    drive(1'b1, 4'h0, 32'h8, 32'h0);
    cyc();
    check("b2b_8", rdata, 32'hDE22_BE44);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    cyc();
    check("idle_hold1", rdata, 32'hDE22_BE44);
    drive(1'b0, 4'hF, 32'h8, 32'hFFFF_FFFF);
    cyc();
    check("idle_hold2", rdata, 32'hDE22_BE44);
    drive(1'b1, 4'h0, 32'h3C, 32'h0);
    cyc();
    check("top_word", rdata, 32'h7700_0000);
    check("no_err_yet", {31'h0, err}, 32'h0);

    // Errors: misaligned read, then out-of-range read and bad writes.
    drive(1'b1, 4'h0, 32'h6, 32'h0);
    cyc();
    check("mis_rdata", rdata, 32'h0);
    check("mis_err", {31'h0, err}, 32'h1);
    check("mis_err_addr", err_addr, 32'h6);
    drive(1'b1, 4'h0, 32'h4, 32'h0);
    cyc();
    check("ok_after_err", rdata, 32'h0102_0304);
    drive(1'b1, 4'h0, 32'h40, 32'h0);
    cyc();
    check("oor_rdata", rdata, 32'h0);
    check("oor_err", {31'h0, err}, 32'h1);
    check("oor_err_addr", err_addr, 32'h6);
    drive(1'b1, 4'hF, 32'h40, 32'hFFFF_FFFF);
    cyc();
    drive(1'b1, 4'hF, 32'h5, 32'hFFFF_FFFF);
    cyc();
    drive(1'b1, 4'hF, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
    cyc();
    check("err_addr_keep", err_addr, 32'h6);
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    cyc();
    check("err_nowr_0", rdata, 32'hA5A5_A5A5);
    drive(1'b1, 4'h0, 32'h4, 32'h0);
    cyc();
    check("err_nowr_4", rdata, 32'h0102_0304);
    drive(1'b1, 4'h0, 32'h38, 32'h0);
    cyc();
    check("err_nowr_38", rdata, 32'h0);

    // Asynchronous reset mid-RUN, away from any clock edge.
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_ready", {31'h0, ready}, 32'h0);
    check("arst_rdata", rdata, 32'h0);
    check("arst_err", {31'h0, err}, 32'h0);
    check("arst_err_addr", err_addr, 32'h0);
    cyc();
    rstn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      check($sformatf("init2_ready%0d", i), {31'h0, ready}, (i == 16) ? 32'h1 : 32'h0);
    end
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    cyc();
    check("reinit_w0", rdata, 32'h0);
    drive(1'b1, 4'h0, 32'h4, 32'h0);
    cyc();
    check("reinit_w1", rdata, 32'h0);
    drive(1'b1, 4'h0, 32'h3C, 32'h0);
    cyc();
    check("reinit_w15", rdata, 32'h0);
    drive(1'b1, 4'h0, 32'h8, 32'h0);
    cyc();
    check("reinit_w2", rdata, 32'h0);
    drive(1'b0, 4'h0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit words (default 1024 words, 4 KB).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_sram_en  input  1  access request from the execute stage, valid this cycle.
REQ-006 SHALL have port data_sram_we  input  4  byte-lane write enables; 4'b0000 with en=1 is a read.
REQ-007 SHALL have port data_sram_addr  input  32  byte address of the access.
REQ-008 SHALL have port data_sram_wdata  input  32  store data; lane i is bits [8i+7:8i].
REQ-009 SHALL have port data_sram_rdata  output  32  registered read data, consumed by the memory stage one cycle after the request.
REQ-010 SHALL have port data_sram_ready  output  1  high once memory initialisation has completed.
REQ-011 SHALL have port data_sram_err  output  1  sticky access-error flag.
REQ-012 SHALL have port data_sram_err_addr  output  32  byte address of the first erroring access.

Function
REQ-013 SHALL implement a two-state FSM, INIT and RUN; reset enters INIT with the word counter at 0.
REQ-014 In INIT it SHALL write 32'h0 to word[counter] each cycle and increment the counter.
REQ-015 The FSM SHALL move to RUN in the cycle after the write to word 2^DEPTH_LOG2-1; the counter width SHALL be DEPTH_LOG2+1 so that no wrap occurs.
REQ-016 data_sram_ready SHALL be 1 exactly when the state is RUN (registered; INIT lasts 2^DEPTH_LOG2 cycles).
REQ-017 Requests in INIT SHALL be ignored: no write, rdata unchanged, err unchanged.
REQ-018 In RUN, offset = addr - BASE_ADDR (32-bit wrap) and index = offset[DEPTH_LOG2+1:2].
REQ-019 A request SHALL be an error if offset >= 4*2^DEPTH_LOG2 (out of range) or addr[1:0] != 2'b00 (misaligned).
REQ-020 A valid read (en=1, we=0, no error) SHALL set rdata to word[index] on the next rising edge; read latency SHALL be 1 cycle.
REQ-021 A valid write (en=1, we!=0, no error) SHALL update only the enabled byte lanes of word[index] on the next rising edge; rdata SHALL hold its previous value.
REQ-022 A read in the cycle after a write to the same index SHALL return the newly written data, with no stall.
REQ-023 With en=0, memory and rdata SHALL hold.
REQ-024 An erroring request SHALL perform no write and SHALL set rdata to 32'h0 on the next edge.
REQ-025 An erroring request SHALL set err=1; err_addr SHALL capture addr only when err was 0 before that edge.
REQ-026 err and err_addr SHALL remain held until reset.
REQ-027 The block SHALL always accept a request in RUN (no back-pressure); the single port permits one access per cycle.

Reset
REQ-028 On rstn=0, regardless of clk, the block SHALL set state=INIT, counter=0, rdata=32'h0, ready=0, err=0 and err_addr=32'h0.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL restart initialisation from word 0; memory contents are then fully re-zeroed before ready rises.
REQ-030 Release of rstn SHALL be synchronised by the system; the block SHALL need no other reset sequencing.

Verification
REQ-031 Reset, then idle with DEPTH_LOG2=4 -> ready rises exactly 16 cycles after rstn deasserts; a read of every word returns 32'h0.
REQ-032 Write addr=0x8, we=4'hF, wdata=0xDEADBEEF, then read addr=0x8 on the next cycle -> rdata=0xDEADBEEF one cycle after the read.
REQ-033 Partial write: after REQ-032, write addr=0x8, we=4'b0101, wdata=0x11223344, then read 0x8 -> rdata=0xDE22BE44.
REQ-034 Read addr=0x6 (misaligned) -> rdata=0, err=1, err_addr=0x6; a later read of addr=4*2^DEPTH_LOG2 keeps err_addr=0x6; no memory word changes.
REQ-035 Back-to-back reads of addrs 0x0, 0x4, 0x8 on consecutive cycles -> rdata sequence matches each word with 1-cycle latency; en=0 afterwards holds the last value.
REQ-036 Request a write to 0x0 during INIT, then assert rstn=0 mid-RUN -> the INIT write is dropped; after re-init, word 0 = 0 and ready stays low for 2^DEPTH_LOG2 cycles.
